multi_cycle_core: RTL and testbench

- Multi-cycle 32-bit MIPS-subset CPU core with one level of external interrupt.
- Sits under the system top and drives a unified instruction/data bus: RAM at 0x0000_xxxx, VRAM at 0x1000_xxxx, I/O at 0xFFFF_xxxx.
- The bus decoder returns read data and a ready strobe (mio_ready); the core stalls while mio_ready is low.
- Exposes pc, current instruction and FSM state for debug displays.

---
 rtl/mcc_pkg.sv | 104 ++++++++++
 rtl/mcc_alu.sv | 34 +++
 rtl/multi_cycle_core.sv | 213 +++++++++++++++++++++
 tb/tb_multi_cycle_core.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mcc_pkg.sv
// Shared constants for the multi-cycle MIPS-subset core:
// opcodes, functs, FSM state codes and ALU operations.
package mcc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_COP0  = 6'h10;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ERET = 6'h18;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  typedef enum logic [4:0] {
    S_IF   = 5'd0,
    S_ID   = 5'd1,
    S_EX_R = 5'd2,
    S_EX_I = 5'd3,
    S_MA   = 5'd4,
    S_MR   = 5'd5,
    S_MW   = 5'd6,
    S_WB_R = 5'd7,
    S_WB_I = 5'd8,
    S_WB_L = 5'd9,
    S_BR   = 5'd10,
    S_JMP  = 5'd11,
    S_INT  = 5'd12,
    S_ERET = 5'd13
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_LUI
  } alu_op_t;

  function automatic logic is_r_alu(input logic [5:0] f);
    return f inside {F_SLL, F_SRL, F_SRA, F_ADD,
                     F_ADDU, F_SUB, F_SUBU, F_AND,
                     F_OR, F_XOR, F_NOR, F_SLT};
  endfunction

  function automatic alu_op_t r_alu_op(input logic [5:0] f);
    case (f)
      F_SUB, F_SUBU: return ALU_SUB;
      F_AND:         return ALU_AND;
      F_OR:          return ALU_OR;
      F_XOR:         return ALU_XOR;
      F_NOR:         return ALU_NOR;
      F_SLT:         return ALU_SLT;
      F_SLL:         return ALU_SLL;
      F_SRL:         return ALU_SRL;
      F_SRA:         return ALU_SRA;
      default:       return ALU_ADD;
    endcase
  endfunction

  function automatic logic is_i_alu(input logic [5:0] op);
    return op inside {OP_ADDI, OP_ADDIU, OP_SLTI,
                      OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
  endfunction

  function automatic alu_op_t i_alu_op(input logic [5:0] op);
    case (op)
      OP_SLTI: return ALU_SLT;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_XORI: return ALU_XOR;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mcc_alu.sv
// Combinational 32-bit ALU with zero flag.
// Shifts operate on i_b by i_shamt; LUI places i_b[15:0] high.
module mcc_alu
  import mcc_pkg::*;
(
  input  alu_op_t     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [4:0]  i_shamt,
  output logic [31:0] o_y,
  output logic        o_zero
);

  always_comb begin
    o_y = '0;
    unique case (i_op)
      ALU_ADD: o_y = i_a + i_b;
      ALU_SUB: o_y = i_a - i_b;
      ALU_AND: o_y = i_a & i_b;
      ALU_OR:  o_y = i_a | i_b;
      ALU_XOR: o_y = i_a ^ i_b;
      ALU_NOR: o_y = ~(i_a | i_b);
      ALU_SLT: o_y = {31'd0, $signed(i_a) < $signed(i_b)};
      ALU_SLL: o_y = i_b << i_shamt;
      ALU_SRL: o_y = i_b >> i_shamt;
      ALU_SRA: o_y = $signed(i_b) >>> i_shamt;
      ALU_LUI: o_y = {i_b[15:0], 16'h0000};
      default: o_y = '0;
    endcase
  end

  assign o_zero = (o_y == 32'd0);

endmodule

// File: rtl/multi_cycle_core.sv
// Multi-cycle MIPS-subset core with one interrupt level.
// Single bus for fetch and data; stalls on mio_ready low.
module multi_cycle_core
  import mcc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0004
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        mio_ready,
  input  logic        INTsignal,
  input  logic [31:0] data_in,
  output logic        mem_w,
  output logic [31:0] addr_out,
  output logic [31:0] data_out,
  output logic [31:0] pc_out,
  output logic [31:0] inst,
  output logic [4:0]  state
);

  state_t      r_state;
  state_t      w_next;
  state_t      w_dispatch;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_imm;
  logic [31:0] r_alu;
  logic [31:0] r_mdr;
  logic [31:0] r_epc;
  logic        r_ie;
  logic [31:0] r_gpr [1:31];

  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_funct;
  logic [31:0] w_sext;
  logic [31:0] w_zext;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic        w_int;

  alu_op_t     w_alu_op;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_y;
  logic        w_alu_zero;
  logic        w_taken;

  logic        w_we;
  logic [4:0]  w_wa;
  logic [31:0] w_wd;

  assign w_op    = r_ir[31:26];
  assign w_rs    = r_ir[25:21];
  assign w_rt    = r_ir[20:16];
  assign w_rd    = r_ir[15:11];
  assign w_funct = r_ir[5:0];
  assign w_sext  = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_zext  = {16'h0000, r_ir[15:0]};

  assign w_rs_val = (w_rs == 5'd0) ? '0 : r_gpr[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? '0 : r_gpr[w_rt];
  assign w_int    = INTsignal & r_ie;

  always_comb begin
    w_dispatch = S_IF;
    unique case (1'b1)
      (w_op == OP_RTYPE) && is_r_alu(w_funct):
        w_dispatch = S_EX_R;
      is_i_alu(w_op):
        w_dispatch = S_EX_I;
      (w_op == OP_LW) || (w_op == OP_SW):
        w_dispatch = S_MA;
      (w_op == OP_BEQ) || (w_op == OP_BNE):
        w_dispatch = S_BR;
      (w_op == OP_J) || (w_op == OP_JAL) ||
      ((w_op == OP_RTYPE) && (w_funct == F_JR)):
        w_dispatch = S_JMP;
      (w_op == OP_COP0) && (w_funct == F_ERET):
        w_dispatch = S_ERET;
      default: w_dispatch = S_IF;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IF: begin
        if (w_int)          w_next = S_INT;
        else if (mio_ready) w_next = S_ID;
      end
      S_ID:   w_next = w_dispatch;
      S_EX_R: w_next = S_WB_R;
      S_EX_I: w_next = S_WB_I;
      S_MA:   w_next = (w_op == OP_LW) ? S_MR : S_MW;
      S_MR:   if (mio_ready) w_next = S_WB_L;
      S_MW:   if (mio_ready) w_next = S_IF;
      default: w_next = S_IF;
    endcase
  end

  always_comb begin
    w_alu_op = ALU_ADD;
    w_alu_b  = r_b;
    unique case (r_state)
      S_EX_R: w_alu_op = r_alu_op(w_funct);
      S_EX_I: begin
        w_alu_op = i_alu_op(w_op);
        w_alu_b  = (w_op inside {OP_ANDI, OP_ORI, OP_XORI})
                   ? w_zext : r_imm;
      end
      S_MA:   w_alu_b  = r_imm;
      S_BR:   w_alu_op = ALU_SUB;
      default: w_alu_op = ALU_ADD;
    endcase
  end

  mcc_alu u_alu (
    .i_op    (w_alu_op),
    .i_a     (r_a),
    .i_b     (w_alu_b),
    .i_shamt (r_ir[10:6]),
    .o_y     (w_alu_y),
    .o_zero  (w_alu_zero)
  );

  assign w_taken = (w_op == OP_BEQ) ? w_alu_zero : !w_alu_zero;

  always_comb begin
    w_we = 1'b0;
    w_wa = w_rt;
    w_wd = r_alu;
    unique case (r_state)
      S_WB_R: begin
        w_we = 1'b1;
        w_wa = w_rd;
      end
      S_WB_I: w_we = 1'b1;
      S_WB_L: begin
        w_we = 1'b1;
        w_wd = r_mdr;
      end
      S_JMP: begin
        w_we = (w_op == OP_JAL);
        w_wa = 5'd31;
        w_wd = r_pc;
      end
      default: w_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IF;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= '0;
      r_alu   <= '0;
      r_mdr   <= '0;
      r_epc   <= '0;
      r_ie    <= 1'b1;
      for (int i = 1; i < 32; i++) r_gpr[i] <= '0;
    end else begin
      r_state <= w_next;
      if (w_we && (w_wa != 5'd0)) r_gpr[w_wa] <= w_wd;
      unique case (r_state)
        S_IF: begin
          if (!w_int && mio_ready) begin
            r_ir <= data_in;
            r_pc <= r_pc + 32'd4;
          end
        end
        S_ID: begin
          r_a   <= w_rs_val;
          r_b   <= w_rt_val;
          r_imm <= w_sext;
        end
        S_EX_R, S_EX_I, S_MA: r_alu <= w_alu_y;
        S_MR: if (mio_ready) r_mdr <= data_in;
        S_BR: if (w_taken) r_pc <= r_pc + (r_imm << 2);
        S_JMP: begin
          if (w_op == OP_RTYPE) r_pc <= r_a;
          else r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
        end
        S_INT: begin
          r_epc <= r_pc;
          r_pc  <= INT_VECTOR;
          r_ie  <= 1'b0;
        end
        S_ERET: begin
          r_pc <= r_epc;
          r_ie <= 1'b1;
        end
        default: r_ie <= r_ie;
      endcase
    end
  end

  assign mem_w    = (r_state == S_MW);
  assign addr_out = (r_state == S_MR || r_state == S_MW)
                    ? r_alu : r_pc;
  assign data_out = r_b;
  assign pc_out   = r_pc;
  assign inst     = r_ir;
  assign state    = r_state;

endmodule

// File: tb/tb_multi_cycle_core.sv
// Directed bench for multi_cycle_core: small program in a
// bench memory, stores observed on the bus, state/PC traced.
module tb_multi_cycle_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mio_ready = 1'b1;
  logic        INTsignal = 1'b0;
  logic [31:0] data_in;
  logic        mem_w;
  logic [31:0] addr_out;
  logic [31:0] data_out;
  logic [31:0] pc_out;
  logic [31:0] inst;
  logic [4:0]  state;

  logic [31:0] mem [0:255];
  int total = 0;
  int bad = 0;

  multi_cycle_core dut (
    .clk       (clk),
    .reset     (reset),
    .mio_ready (mio_ready),
    .INTsignal (INTsignal),
    .data_in   (data_in),
    .mem_w     (mem_w),
    .addr_out  (addr_out),
    .data_out  (data_out),
    .pc_out    (pc_out),
    .inst      (inst),
    .state     (state)
  );

  always #5 clk = ~clk;

  assign data_in = mem[addr_out[9:2]];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input string tag,
                            input logic [4:0] s,
                            input logic [31:0] pc);
    int n = 0;
    while (!(state === s && pc_out === pc) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {27'd0, state, pc_out}, {27'd0, s, pc});
  endtask

  task automatic expect_write(input string tag,
                              input logic [31:0] a,
                              input logic [31:0] d);
    int n = 0;
    while (state !== 5'd6 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_we"}, {63'd0, mem_w}, 64'd1);
    chk({tag, "_addr"}, {32'd0, addr_out}, {32'd0, a});
    chk({tag, "_data"}, {32'd0, data_out}, {32'd0, d});
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem['h000 >> 2] = 32'h08000080; // j 0x200
    mem['h004 >> 2] = 32'h20060001; // addi $6,$0,1
    mem['h008 >> 2] = 32'h42000018; // eret
    mem['h010 >> 2] = 32'hDEADBEEF;
    mem['h020 >> 2] = 32'h10000002; // beq $0,$0,+2
    mem['h024 >> 2] = 32'h200A0001;
    mem['h028 >> 2] = 32'h200A0001;
    mem['h02C >> 2] = 32'h0C000040; // jal 0x100
    mem['h030 >> 2] = 32'hAC1F0020; // sw $31,0x20
    mem['h034 >> 2] = 32'h0800000D; // j 0x34
    mem['h100 >> 2] = 32'h03E00008; // jr $31
    mem['h200 >> 2] = 32'h20010005; // addi $1,$0,5
    mem['h204 >> 2] = 32'h2002FFFD; // addi $2,$0,-3
    mem['h208 >> 2] = 32'h00221820; // add $3,$1,$2
    mem['h20C >> 2] = 32'hAC030010; // sw $3,0x10
    mem['h210 >> 2] = 32'h8C040010; // lw $4,0x10
    mem['h214 >> 2] = 32'hAC040014; // sw $4,0x14
    mem['h218 >> 2] = 32'h20000007; // addi $0,$0,7
    mem['h21C >> 2] = 32'hAC000018; // sw $0,0x18
    mem['h220 >> 2] = 32'h3C051000; // lui $5,0x1000
    mem['h224 >> 2] = 32'hAC05001C; // sw $5,0x1C
    mem['h228 >> 2] = 32'h00223022; // sub $6,$1,$2
    mem['h22C >> 2] = 32'h0041382A; // slt $7,$2,$1
    mem['h230 >> 2] = 32'h00024043; // sra $8,$2,1
    mem['h234 >> 2] = 32'h3049F0F0; // andi $9,$2,0xF0F0
    mem['h238 >> 2] = 32'h14220001; // bne $1,$2,+1
    mem['h23C >> 2] = 32'h200A0001; // skipped
    mem['h240 >> 2] = 32'hAC060024;
    mem['h244 >> 2] = 32'hAC070028;
    mem['h248 >> 2] = 32'hAC08002C;
    mem['h24C >> 2] = 32'hAC090030;
    mem['h250 >> 2] = 32'hAC0A0034;
    mem['h254 >> 2] = 32'h08000008; // j 0x20

    #2 reset = 1'b1;
    #1;
    chk("rst_state", {59'd0, state}, 64'd0);
    chk("rst_pc", {32'd0, pc_out}, 64'd0);
    chk("rst_ir", {32'd0, inst}, 64'd0);
    chk("rst_memw", {63'd0, mem_w}, 64'd0);
    chk("rst_dout", {32'd0, data_out}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    wait_state("reach_200", 5'd0, 32'h200);
    @(negedge clk) chk("addi_s1", {59'd0, state}, 64'd1);
    @(negedge clk) chk("addi_s2", {59'd0, state}, 64'd3);
    @(negedge clk) chk("addi_s3", {59'd0, state}, 64'd8);
    @(negedge clk);
    chk("addi_s4", {27'd0, state, pc_out}, {27'd0, 5'd0, 32'h204});

    wait_state("reach_mw", 5'd6, 32'h210);
    mio_ready = 1'b0;
    chk("sw3_we", {63'd0, mem_w}, 64'd1);
    chk("sw3_addr", {32'd0, addr_out}, 64'h10);
    chk("sw3_data", {32'd0, data_out}, 64'd2);
    @(negedge clk);
    chk("mw_hold", {27'd0, state, addr_out}, {27'd0, 5'd6, 32'h10});
    reset = 1'b1;
    #1;
    chk("midrst_memw", {63'd0, mem_w}, 64'd0);
    chk("midrst_pc", {32'd0, pc_out}, 64'd0);
    chk("midrst_state", {59'd0, state}, 64'd0);
    chk("midrst_dout", {32'd0, data_out}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    mio_ready = 1'b1;

    expect_write("sw3b", 32'h10, 32'd2);
    wait_state("reach_mr", 5'd5, 32'h214);
    chk("lw_addr", {32'd0, addr_out}, 64'h10);
    mio_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lw_stall", {59'd0, state}, 64'd5);
    end
    mio_ready = 1'b1;
    @(negedge clk) chk("lw_wbl", {59'd0, state}, 64'd9);

    expect_write("sw4", 32'h14, 32'hDEADBEEF);
    expect_write("sw0", 32'h18, 32'h0);
    expect_write("lui", 32'h1C, 32'h1000_0000);
    expect_write("sub", 32'h24, 32'd8);
    expect_write("slt", 32'h28, 32'd1);
    expect_write("sra", 32'h2C, 32'hFFFF_FFFE);
    expect_write("andi", 32'h30, 32'h0000_F0F0);
    expect_write("bne", 32'h34, 32'h0);

    wait_state("reach_20", 5'd0, 32'h20);
    repeat (3) @(negedge clk);
    chk("beq", {27'd0, state, pc_out}, {27'd0, 5'd0, 32'h2C});
    repeat (3) @(negedge clk);
    chk("jal", {27'd0, state, pc_out}, {27'd0, 5'd0, 32'h100});
    repeat (3) @(negedge clk);
    chk("jr", {27'd0, state, pc_out}, {27'd0, 5'd0, 32'h30});

    INTsignal = 1'b1;
    @(negedge clk) chk("int_state", {59'd0, state}, 64'd12);
    @(negedge clk);
    chk("int_vec", {27'd0, state, pc_out}, {27'd0, 5'd0, 32'h4});
    @(negedge clk) chk("int_masked", {59'd0, state}, 64'd1);
    wait_state("isr_eret", 5'd0, 32'h8);
    @(negedge clk) chk("eret_id", {59'd0, state}, 64'd1);
    @(negedge clk) chk("eret_st", {59'd0, state}, 64'd13);
    INTsignal = 1'b0;
    @(negedge clk);
    chk("eret_pc", {27'd0, state, pc_out}, {27'd0, 5'd0, 32'h30});
    expect_write("ra", 32'h20, 32'h30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
